// File: rtl/serial_pkg.sv
// Shared constants for the serial transmitter: state encoding, line levels, frame shape.
package serial_pkg;

    // Binary-encoded transmitter states; StParity only used when parity is built in.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    // Line level while idle and during the stop bit(s).
    localparam logic IDLE_LEVEL = 1'b1;
    // Line level of the start bit.
    localparam logic START_LEVEL = 1'b0;
    // Number of stop bit times appended to every frame.
    localparam int unsigned STOP_BITS = 1;

    // Width of the per-frame bit counter (covers data bits and stop bits).
    localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/baud_gen.sv
// Bit-time generator: counts enabled cycles and raises TICK on the last enabled
// cycle of each bit time. CLEAR holds the count at zero (used while idle).
module baud_gen #(
    parameter int unsigned CLK_DIV = 5208
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    input  logic CLEAR,
    output logic TICK
);

    localparam logic [15:0] LAST_CNT = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q;

    // Tick is combinational so the FSM can act on the same edge that ends the bit time.
    always_comb begin
        TICK = ENABLE && !CLEAR && (cnt_q == LAST_CNT);
    end

    // Enabled-cycle counter; frozen when ENABLE is low, wraps at the end of each bit time.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (ENABLE) begin
            if (CLEAR || TICK) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_BITS payload bits LSB first, optional even
// parity bit, stop bit(s). Parity is built in when SERIAL_TX_PARITY_EN is defined.
// All outputs are registered; ENABLE freezes every piece of state.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 5208,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic [DATA_BITS-1:0] DATA,
    input  logic                 LOAD,
    output logic                 TXD,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    tx_state_e              state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   tick;
    logic                   baud_clear;
`ifdef SERIAL_TX_PARITY_EN
    logic                   parity_q;
`endif

    // Bit timing runs only while a frame is in flight, so every frame starts on a fresh count.
    always_comb begin
        baud_clear = (state_q == StIdle);
    end

    baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_gen (
        .CLK   (CLK),
        .RESET (RESET),
        .ENABLE(ENABLE),
        .CLEAR (baud_clear),
        .TICK  (tick)
    );

    // Frame sequencer with registered TXD/BUSY/DONE; each output changes on the edge
    // that enters the new state so TXD never passes through combinational logic.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            TXD       <= IDLE_LEVEL;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (ENABLE) begin
            DONE <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The DONE cycle is an idle cycle, so back-to-back loads land here.
                    if (LOAD) begin
                        shreg_q  <= DATA;
                        state_q  <= StStart;
                        TXD      <= START_LEVEL;
                        BUSY     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q <= ^DATA;
`endif
                    end
                end
                StStart: begin
                    if (tick) begin
                        state_q   <= StData;
                        TXD       <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        bit_cnt_q <= '0;
                    end
                end
                StData: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            state_q   <= StParity;
                            TXD       <= parity_q;
`else
                            state_q   <= StStop;
                            TXD       <= IDLE_LEVEL;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            TXD       <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                StParity: begin
                    if (tick) begin
                        state_q <= StStop;
                        TXD     <= IDLE_LEVEL;
                    end
                end
`endif
                StStop: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            state_q   <= StIdle;
                            TXD       <= IDLE_LEVEL;
                            BUSY      <= 1'b0;
                            DONE      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    TXD       <= IDLE_LEVEL;
                    BUSY      <= 1'b0;
                    bit_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx (CLK_DIV=4, DATA_BITS=8). A frame-level model
// checks every cycle; directed frames also check hand-written bit patterns.
module tb_serial_tx;

    localparam int unsigned DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
    localparam int EXP_BUSY = 44;
    localparam int EXP_BUSY_STALL = 54;
    localparam logic [10:0] LIT_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
    localparam logic [10:0] LIT_3C = {1'b1, 1'b0, 8'h3C, 1'b0};
    localparam logic [10:0] LIT_81 = {1'b1, 1'b0, 8'h81, 1'b0};
    localparam logic [10:0] LIT_C3 = {1'b1, 1'b0, 8'hC3, 1'b0};
    localparam logic [10:0] LIT_07 = {1'b1, 1'b1, 8'h07, 1'b0};
`else
    localparam int NB = 10;
    localparam int EXP_BUSY = 40;
    localparam int EXP_BUSY_STALL = 50;
    localparam logic [10:0] LIT_A5 = {1'b0, 1'b1, 8'hA5, 1'b0};
    localparam logic [10:0] LIT_3C = {1'b0, 1'b1, 8'h3C, 1'b0};
    localparam logic [10:0] LIT_81 = {1'b0, 1'b1, 8'h81, 1'b0};
    localparam logic [10:0] LIT_C3 = {1'b0, 1'b1, 8'hC3, 1'b0};
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic       load;
    logic       txd;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    bit check_on = 0;

    serial_tx #(
        .CLK_DIV  (DIV),
        .DATA_BITS(8)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .ENABLE(en),
        .DATA  (data),
        .LOAD  (load),
        .TXD   (txd),
        .BUSY  (busy),
        .DONE  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Frame-level model: a frame is a list of line levels, each held DIV enabled cycles.
    logic        m_txd = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [10:0] m_frame = '0;
    int          m_idx = 0;
    int          m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_txd = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_idx = 0; m_cnt = 0;
        end else if (en) begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (load) begin
`ifdef SERIAL_TX_PARITY_EN
                    m_frame = {1'b1, ^data, data, 1'b0};
`else
                    m_frame = {1'b0, 1'b1, data, 1'b0};
`endif
                    m_busy = 1'b1; m_idx = 0; m_cnt = 0; m_txd = m_frame[0];
                end
            end else begin
                m_cnt++;
                if (m_cnt == DIV) begin
                    m_cnt = 0;
                    m_idx++;
                    if (m_idx == NB) begin
                        m_busy = 1'b0; m_done = 1'b1; m_txd = 1'b1;
                    end else begin
                        m_txd = m_frame[m_idx];
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_on) begin
            chk("txd", 32'(txd), 32'(m_txd));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends one frame starting in the current cycle and checks it against a literal pattern.
    task automatic check_frame(input logic [7:0] d, input logic [10:0] lit, input int stall_at,
                               input int stall_len, input bit noise, input int exp_busy,
                               input string name);
        int   total;
        int   n;
        int   busy_cnt;
        int   done_cnt;
        int   done_pos;
        logic en_prev;
        logic rec [0:63];
        total = DIV * NB + stall_len + 1;
        load = 1'b1; data = d; en = 1'b1; en_prev = 1'b1;
        n = 0; busy_cnt = 0; done_cnt = 0; done_pos = 0;
        for (int c = 1; c <= total; c++) begin
            step();
            if (en_prev) begin
                rec[n] = txd;
                n++;
            end
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                done_pos = c;
            end
            load = 1'b0;
            if (noise && c < total && $urandom_range(0, 2) == 0) begin
                load = 1'b1;
                data = 8'($urandom);
            end
            en = !(c >= stall_at && c < stall_at + stall_len);
            en_prev = en;
        end
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < int'(DIV); j++) begin
                chk($sformatf("%s_bit%0d_%0d", name, k, j), 32'(rec[k * DIV + j]), 32'(lit[k]));
            end
        end
        chk($sformatf("%s_idle_after", name), 32'(rec[DIV * NB]), 32'd1);
        chk($sformatf("%s_busy_len", name), 32'(busy_cnt), 32'(exp_busy));
        chk($sformatf("%s_done_pos", name), 32'(done_pos), 32'(total));
        chk($sformatf("%s_done_cnt", name), 32'(done_cnt), 32'd1);
        chk($sformatf("%s_busy_at_done", name), 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; data = '0;
        step();
        check_on = 1'b1;
        en = 1'b0;
        step();
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0; en = 1'b1;
        step();

        // Basic frame, then a back-to-back frame loaded in the DONE cycle.
        check_frame(8'hA5, LIT_A5, 0, 0, 1'b0, EXP_BUSY, "a5");
        check_frame(8'h3C, LIT_3C, 0, 0, 1'b0, EXP_BUSY, "b2b_3c");
        repeat (3) step();
`ifdef SERIAL_TX_PARITY_EN
        check_frame(8'h07, LIT_07, 0, 0, 1'b0, EXP_BUSY, "par_07");
        repeat (2) step();
`endif
        // ENABLE low for 10 cycles in the 3rd data bit.
        check_frame(8'hA5, LIT_A5, 14, 10, 1'b0, EXP_BUSY_STALL, "stall");
        repeat (2) step();
        // LOAD pulses and DATA changes mid-frame.
        check_frame(8'hC3, LIT_C3, 0, 0, 1'b1, EXP_BUSY, "noise");
        repeat (2) step();

        // Reset during DATA, with LOAD also asserted.
        load = 1'b1; data = 8'h5A;
        step();
        load = 1'b0;
        repeat (8) step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1; load = 1'b1;
        step();
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0; load = 1'b0;
        step();
        chk("post_rst_done", 32'(done), 32'd0);
        check_frame(8'h81, LIT_81, 0, 0, 1'b0, EXP_BUSY, "after_rst_81");

        // Randomized traffic checked by the model alone.
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 149) == 0);
            en   = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 5) == 0);
            data = 8'($urandom);
            step();
        end
        rst = 1'b0; load = 1'b0; en = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
